// File: rtl/ifstage_prefetch.sv
// rtl/ifstage_prefetch.sv - instruction fetch stage with PC, 1-cycle imem port and prefetch FIFO
module ifstage_prefetch #(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              Clk,
    input  logic              Reset_n,
    output logic              Imem_En,
    output logic [ADDR_W-1:0] Imem_Addr,
    input  logic [31:0]       Imem_Data,
    input  logic              Redir_Valid,
    input  logic              Redir_Abs,
    input  logic [ADDR_W-1:0] Redir_Base,
    input  logic [31:0]       Redir_Imm,
    output logic              Redir_Misalign,
    output logic [31:0]       Instr,
    output logic [ADDR_W-1:0] Instr_PC,
    output logic              Instr_Valid,
    input  logic              Instr_Ready
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]       mem_data [DEPTH];
    logic [ADDR_W-1:0] mem_pc   [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    occupancy;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] req_pc;
    logic [ADDR_W-1:0] imm_w;
    logic [ADDR_W-1:0] target;
    logic              inflight;
    logic              running;
    logic              misalign;
    logic              pop;
    logic              push;
    logic              issue;

    generate
        if (ADDR_W <= 32) begin : g_imm_trunc
            assign imm_w = Redir_Imm[ADDR_W-1:0];
        end else begin : g_imm_sext
            assign imm_w = {{(ADDR_W-32){Redir_Imm[31]}}, Redir_Imm};
        end
    endgenerate

    always_comb begin
        target = Redir_Base + ADDR_W'(4) + {imm_w[ADDR_W-3:0], 2'b00};
        if (Redir_Abs) begin
            target = {imm_w[ADDR_W-1:2], 2'b00};
        end
    end

    assign Instr_Valid = (count != '0);
    assign pop         = Instr_Valid && Instr_Ready;
    assign push        = inflight && !Redir_Valid;

    // Counting the in-flight response as occupied guarantees it always finds a free slot.
    assign occupancy = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
    assign issue     = running && !Redir_Valid && (occupancy < (CNT_W+1)'(DEPTH));

    assign Imem_En        = issue;
    assign Imem_Addr      = pc;
    assign Instr          = mem_data[rd_ptr];
    assign Instr_PC       = mem_pc[rd_ptr];
    assign Redir_Misalign = misalign;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            running  <= 1'b0;
            pc       <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
            misalign <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
        end else begin
            running <= 1'b1;
            if (Redir_Valid) begin
                pc       <= target;
                inflight <= 1'b0;
                misalign <= Redir_Abs && (imm_w[1:0] != 2'b00);
                count    <= '0;
                rd_ptr   <= '0;
            end else begin
                inflight <= issue;
                misalign <= 1'b0;
                count    <= count + CNT_W'(push) - CNT_W'(pop);
                if (issue) begin
                    pc     <= pc + ADDR_W'(4);
                    req_pc <= pc;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_pc[i]   <= '0;
            end
            wr_ptr <= '0;
        end else if (Redir_Valid) begin
            wr_ptr <= '0;
        end else if (push) begin
            mem_data[wr_ptr] <= Imem_Data;
            mem_pc[wr_ptr]   <= req_pc;
            wr_ptr           <= wr_ptr + PTR_W'(1);
        end
    end
endmodule
